d_cache_ctrl: RTL and testbench
===============================

// Module: d_cache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU data port and the
//  d_* port of the block memory. Serves 16-bit CPU loads/stores; misses move whole 4-word
//  blocks (64 bits) over the memory's shared inout bus with a fixed, parameterised latency.
//  Hit/miss counters are exported for the performance testbench.
// PARAMETERS
//  NUM_LINES    4   cache lines; power of 2; index = addr[2+log2(NUM_LINES)-1:2]
//  MEM_LATENCY  4   cycles m_readM/m_writeM held per block transfer; must be >= 2
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   synchronous, active-low reset
//  cpu_read     in   1   load request; held stable until cpu_ready
//  cpu_write    in   1   store request; held stable until cpu_ready
//  cpu_address  in   16  word address
//  cpu_wdata    in   16  store data
//  cpu_rdata    out  16  load data; valid only while cpu_ready=1
//  cpu_ready    out  1   one-cycle completion pulse
//  m_readM      out  1   memory block read strobe
//  m_writeM     out  1   memory block write strobe
//  m_address    out  16  block-aligned address {addr[15:2],2'b00}
//  m_data       inout 64 block bus; word0 in [63:48] ... word3 in [15:0]; cache drives only when m_writeM=1, else 'z
//  hit_count    out  16  accesses that hit; saturates at 16'hFFFF
//  miss_count   out  16  accesses that missed; saturates at 16'hFFFF
// BEHAVIOUR
//  - Address split: offset=addr[1:0], index as above, tag=remaining upper bits. Per line: valid, dirty, tag, 4x16 data.
//  - Reset: all valid/dirty=0, FSM=IDLE, cpu_ready=0, cpu_rdata=0, m_readM=m_writeM=0, m_address=0, counters=0.
//    Reset mid-transfer aborts it the same edge; dirty data is discarded.
//  - FSM states IDLE, WB, FILL, RESP.
//  - IDLE, request present in cycle N: hit -> RESP at N+1 (store writes word and sets dirty at end of N);
//    miss+victim clean/invalid -> FILL; miss+victim valid&dirty -> WB. hit_count/miss_count
//    increment once per access, at the IDLE decision edge.
//  - cpu_read & cpu_write both 1: treated as a store.
//  - WB: m_writeM=1, m_address={victim tag,index,2'b00}, m_data=victim block, for MEM_LATENCY cycles; then FILL.
//  - FILL: m_readM=1, m_address={req addr[15:2],2'b00}, for MEM_LATENCY cycles; m_data captured at the edge
//    ending the last FILL cycle (memory output is registered, hence MEM_LATENCY>=2). Line gets valid=1,
//    new tag, dirty=0; a pending store then merges cpu_wdata and sets dirty=1. Next state RESP.
//  - m_readM and m_writeM never both 1; WB->FILL has no idle cycle between strobes.
//  - RESP: cpu_ready=1 for exactly one cycle, cpu_rdata = addressed word (post-merge for stores); -> IDLE.
//    A request held after RESP is treated as a new access in the following IDLE cycle.
//  - Latencies (request-to-ready): hit 1, clean miss MEM_LATENCY+1, dirty miss 2*MEM_LATENCY+1.
//  - cpu_ready=0 and outputs unchanged in IDLE with no request.
// TESTING (memory preloaded mem[0..3]=9023,0001,FFFF,0000, MEM_LATENCY=4)
//  1 Cold read 0x0001 -> m_readM 4 cycles @m_address 0x0000, no m_writeM, cpu_ready at +5, rdata 0x0001, miss_count=1.
//  2 Then read 0x0002 -> cpu_ready at +1, rdata 0xFFFF, no memory strobe, hit_count=1.
//  3 Write 0x0003=0xABCD (hit), then read 0x0013 -> m_writeM 4 cycles, m_address 0x0000,
//    m_data=64'h9023_0001_FFFF_ABCD, then m_readM 4 cycles @0x0010; cpu_ready at +9.
//  4 Read 0x0003 after step 3 -> clean miss, cpu_ready at +5, rdata 0xABCD (write-back verified).
//  5 Assert reset_n=0 during 2nd FILL cycle -> m_readM=0 next edge, counters 0; re-read 0x0002 misses.
//  6 Simultaneous cpu_read=cpu_write=1 to 0x0000, wdata 0x1234 -> store performed; later read returns 0x1234.

Source files
------------

// File: rtl/d_cache_ctrl_if.sv
// CPU-side request/response signals, memory strobes/address and performance counters
// of the data cache controller. The 64-bit block bus stays a plain inout port on the cache.
interface d_cache_ctrl_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        m_readM;
    logic        m_writeM;
    logic [15:0] m_address;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_wdata,
        input  cpu_rdata, cpu_ready, m_readM, m_writeM, m_address, hit_count, miss_count
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_wdata,
        output cpu_rdata, cpu_ready, m_readM, m_writeM, m_address, hit_count, miss_count
    );
endinterface

// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache: 16-bit CPU words, 4-word blocks
// moved over a shared 64-bit bus with a fixed transfer latency.
module d_cache_ctrl #(
    parameter int NUM_LINES   = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    d_cache_ctrl_if.slave    bus,
    inout  wire  [63:0]      io_m_data
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 14 - IDX_W;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]   r_tag  [NUM_LINES];
    logic [63:0]        r_data [NUM_LINES];
    logic [15:0]        r_rdata;
    logic               r_ready;
    logic               r_m_readM;
    logic               r_m_writeM;
    logic [15:0]        r_m_address;
    logic [63:0]        r_wb_data;
    logic [15:0]        r_hit_count;
    logic [15:0]        r_miss_count;

    logic [1:0]         w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_req;
    logic               w_store;
    logic               w_hit;
    logic               w_victim_dirty;
    logic [63:0]        w_line;
    logic [63:0]        w_line_wr;
    logic [63:0]        w_fill_blk;

    // Word 0 sits in the most significant quarter of a block.
    function automatic logic [15:0] get_word(input logic [63:0] blk, input logic [1:0] off);
        logic [15:0] w;
        case (off)
            2'd0:    w = blk[63:48];
            2'd1:    w = blk[47:32];
            2'd2:    w = blk[31:16];
            default: w = blk[15:0];
        endcase
        return w;
    endfunction

    function automatic logic [63:0] put_word(input logic [63:0] blk, input logic [1:0] off,
                                             input logic [15:0] w);
        logic [63:0] b;
        b = blk;
        case (off)
            2'd0:    b[63:48] = w;
            2'd1:    b[47:32] = w;
            2'd2:    b[31:16] = w;
            default: b[15:0]  = w;
        endcase
        return b;
    endfunction

    assign w_off          = bus.cpu_address[1:0];
    assign w_idx          = bus.cpu_address[2 +: IDX_W];
    assign w_tag          = bus.cpu_address[15:2+IDX_W];
    assign w_req          = bus.cpu_read | bus.cpu_write;
    assign w_store        = bus.cpu_write;
    assign w_line         = r_data[w_idx];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_line_wr      = put_word(w_line, w_off, bus.cpu_wdata);
    // A store that missed merges its word into the incoming block on the capture edge.
    assign w_fill_blk     = w_store ? put_word(io_m_data, w_off, bus.cpu_wdata) : io_m_data;

    assign io_m_data      = r_m_writeM ? r_wb_data : {64{1'bz}};
    assign bus.cpu_rdata  = r_rdata;
    assign bus.cpu_ready  = r_ready;
    assign bus.m_readM    = r_m_readM;
    assign bus.m_writeM   = r_m_writeM;
    assign bus.m_address  = r_m_address;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;

    // Controller FSM, line state and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_rdata      <= 16'h0000;
            r_ready      <= 1'b0;
            r_m_readM    <= 1'b0;
            r_m_writeM   <= 1'b0;
            r_m_address  <= 16'h0000;
            r_wb_data    <= 64'h0;
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (w_req) begin
                        r_cnt <= '0;
                        if (w_hit) begin
                            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
                            if (w_store) begin
                                r_data[w_idx]  <= w_line_wr;
                                r_dirty[w_idx] <= 1'b1;
                            end
                            r_rdata <= w_store ? bus.cpu_wdata : get_word(w_line, w_off);
                            r_ready <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
                            if (w_victim_dirty) begin
                                r_m_writeM  <= 1'b1;
                                r_m_address <= {r_tag[w_idx], w_idx, 2'b00};
                                r_wb_data   <= w_line;
                                r_state     <= S_WB;
                            end else begin
                                r_m_readM   <= 1'b1;
                                r_m_address <= {bus.cpu_address[15:2], 2'b00};
                                r_state     <= S_FILL;
                            end
                        end
                    end
                end
                S_WB: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_m_writeM  <= 1'b0;
                        r_m_readM   <= 1'b1;
                        r_m_address <= {bus.cpu_address[15:2], 2'b00};
                        r_state     <= S_FILL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FILL: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt          <= '0;
                        r_m_readM      <= 1'b0;
                        r_data[w_idx]  <= w_fill_blk;
                        r_tag[w_idx]   <= w_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= w_store;
                        r_rdata        <= get_word(w_fill_blk, w_off);
                        r_ready        <= 1'b1;
                        r_state        <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_d_cache_ctrl.sv
// Bench for d_cache_ctrl: registered block memory model, directed scenarios and a
// randomized run checked against a block-level reference of the CPU-visible memory.
module tb_d_cache_ctrl;
    localparam int L  = 4;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    wire [63:0] m_data;
    d_cache_ctrl_if bus();

    d_cache_ctrl #(.NUM_LINES(NL), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .io_m_data(m_data)
    );

    always #5 clk = ~clk;

    // Block memory: 64 blocks (word addresses 0..255), registered read output.
    logic [63:0] mem [64];
    logic [63:0] mem_out = 64'h0;
    logic        mem_oe  = 1'b0;
    assign m_data = mem_oe ? mem_out : {64{1'bz}};
    always @(posedge clk) begin
        mem_oe <= bus.m_readM;
        if (bus.m_readM) mem_out <= mem[bus.m_address[7:2]];
        if (bus.m_writeM) mem[bus.m_address[7:2]] <= m_data;
    end

    int checks = 0;
    int failures = 0;

    // Reference: CPU-visible memory plus which block each line holds.
    logic [15:0] ref_mem [256];
    logic        lv [NL];
    logic        ld [NL];
    int          lblk [NL];
    int          exp_hit, exp_miss;

    logic        e_hit, e_dirty;
    int          e_lat, e_nrd, e_nwr;
    logic [15:0] e_rdata, e_rd_addr, e_wb_addr;
    logic [63:0] e_wb_data;

    int          o_lat, o_nrd, o_nwr, o_both;
    logic [15:0] o_rdata, o_rd_addr, o_wr_addr;
    logic [63:0] o_wr_data;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin lv[i] = 1'b0; ld[i] = 1'b0; lblk[i] = 0; end
        for (int w = 0; w < 256; w++) ref_mem[w] = mem[w/4][63-16*(w%4) -: 16];
        exp_hit = 0; exp_miss = 0;
    endtask

    task automatic predict(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        int blk, line;
        blk  = int'(addr[7:2]);
        line = blk % NL;
        e_hit   = lv[line] && (lblk[line] == blk);
        e_dirty = !e_hit && lv[line] && ld[line];
        e_lat   = e_hit ? 1 : (e_dirty ? 2*L+1 : L+1);
        e_nrd   = e_hit ? 0 : L;
        e_nwr   = e_dirty ? L : 0;
        e_rd_addr = addr & 16'hFFFC;
        e_wb_addr = 16'(lblk[line] * 4);
        e_wb_data = {ref_mem[lblk[line]*4], ref_mem[lblk[line]*4+1],
                     ref_mem[lblk[line]*4+2], ref_mem[lblk[line]*4+3]};
        if (e_hit) exp_hit++;
        else begin exp_miss++; lv[line] = 1'b1; lblk[line] = blk; ld[line] = 1'b0; end
        if (wr) begin ref_mem[addr[7:0]] = wd; ld[line] = 1'b1; end
        e_rdata = ref_mem[addr[7:0]];
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge leaving RESP.
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        bit done;
        predict(wr, addr, wd);
        bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_address = addr; bus.cpu_wdata = wd;
        o_lat = 0; o_nrd = 0; o_nwr = 0; o_both = 0; o_rdata = 16'h0;
        o_rd_addr = 16'hDEAD; o_wr_addr = 16'hDEAD; o_wr_data = 64'h0;
        done = 1'b0;
        for (int c = 1; c <= 3*L+10 && !done; c++) begin
            @(posedge clk); #1;
            if (bus.m_readM && bus.m_writeM) o_both++;
            if (bus.m_readM) begin o_nrd++; o_rd_addr = bus.m_address; end
            if (bus.m_writeM) begin o_nwr++; o_wr_addr = bus.m_address; o_wr_data = m_data; end
            if (bus.cpu_ready) begin done = 1'b1; o_lat = c; o_rdata = bus.cpu_rdata; end
        end
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.cpu_ready !== 1'b0 || bus.cpu_rdata !== 16'h0) begin failures++;
            $display("FAIL reset_cpu got ready=%b rdata=%h exp 0/0000", bus.cpu_ready, bus.cpu_rdata); end
        checks++; if (bus.m_readM !== 1'b0 || bus.m_writeM !== 1'b0 || bus.m_address !== 16'h0) begin failures++;
            $display("FAIL reset_mem got r=%b w=%b a=%h exp 0/0/0000", bus.m_readM, bus.m_writeM, bus.m_address); end
        checks++; if (bus.hit_count !== 16'h0 || bus.miss_count !== 16'h0) begin failures++;
            $display("FAIL reset_counters got %h/%h exp 0000/0000", bus.hit_count, bus.miss_count); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_cold_read();
        access(1'b1, 1'b0, 16'h0001, 16'h0);
        checks++; if (o_lat !== 5) begin failures++; $display("FAIL cold_latency got=%0d exp=5", o_lat); end
        checks++; if (o_nrd !== 4 || o_rd_addr !== 16'h0000) begin failures++;
            $display("FAIL cold_fill got cycles=%0d addr=%h exp 4/0000", o_nrd, o_rd_addr); end
        checks++; if (o_nwr !== 0) begin failures++; $display("FAIL cold_no_wb got=%0d exp=0", o_nwr); end
        checks++; if (o_rdata !== 16'h0001) begin failures++; $display("FAIL cold_rdata got=%h exp=0001", o_rdata); end
        checks++; if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin failures++;
            $display("FAIL cold_counters got hit=%0d miss=%0d exp 0/1", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_hit_read();
        access(1'b1, 1'b0, 16'h0002, 16'h0);
        checks++; if (o_lat !== 1 || o_nrd !== 0 || o_nwr !== 0) begin failures++;
            $display("FAIL hit_timing got lat=%0d rd=%0d wr=%0d exp 1/0/0", o_lat, o_nrd, o_nwr); end
        checks++; if (o_rdata !== 16'hFFFF) begin failures++; $display("FAIL hit_rdata got=%h exp=ffff", o_rdata); end
        checks++; if (bus.hit_count !== 16'd1) begin failures++; $display("FAIL hit_count got=%0d exp=1", bus.hit_count); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.cpu_ready !== 1'b0 || bus.m_readM !== 1'b0 || bus.m_writeM !== 1'b0) begin failures++;
                $display("FAIL idle_quiet got ready=%b r=%b w=%b exp 0/0/0", bus.cpu_ready, bus.m_readM, bus.m_writeM); end
        end
    endtask

    task automatic test_dirty_evict();
        access(1'b0, 1'b1, 16'h0003, 16'hABCD);
        checks++; if (o_lat !== 1 || o_rdata !== 16'hABCD) begin failures++;
            $display("FAIL store_hit got lat=%0d rdata=%h exp 1/abcd", o_lat, o_rdata); end
        access(1'b1, 1'b0, 16'h0013, 16'h0);
        checks++; if (o_lat !== 9) begin failures++; $display("FAIL evict_latency got=%0d exp=9", o_lat); end
        checks++; if (o_nwr !== 4 || o_wr_addr !== 16'h0000) begin failures++;
            $display("FAIL evict_wb got cycles=%0d addr=%h exp 4/0000", o_nwr, o_wr_addr); end
        checks++; if (o_wr_data !== 64'h9023_0001_FFFF_ABCD) begin failures++;
            $display("FAIL evict_wb_data got=%h exp=9023_0001_ffff_abcd", o_wr_data); end
        checks++; if (o_nrd !== 4 || o_rd_addr !== 16'h0010 || o_both !== 0) begin failures++;
            $display("FAIL evict_fill got cycles=%0d addr=%h both=%0d exp 4/0010/0", o_nrd, o_rd_addr, o_both); end
        checks++; if (o_rdata !== e_rdata) begin failures++; $display("FAIL evict_rdata got=%h exp=%h", o_rdata, e_rdata); end
    endtask

    task automatic test_writeback_reload();
        access(1'b1, 1'b0, 16'h0003, 16'h0);
        checks++; if (o_lat !== 5 || o_nwr !== 0) begin failures++;
            $display("FAIL reload_timing got lat=%0d wr=%0d exp 5/0", o_lat, o_nwr); end
        checks++; if (o_rdata !== 16'hABCD) begin failures++; $display("FAIL reload_rdata got=%h exp=abcd", o_rdata); end
    endtask

    task automatic test_reset_mid_fill();
        bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_address = 16'h0013;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.m_readM !== 1'b1) begin failures++; $display("FAIL midfill_strobe got=%b exp=1", bus.m_readM); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.m_readM !== 1'b0 || bus.cpu_ready !== 1'b0) begin failures++;
            $display("FAIL midfill_abort got r=%b ready=%b exp 0/0", bus.m_readM, bus.cpu_ready); end
        checks++; if (bus.hit_count !== 16'h0 || bus.miss_count !== 16'h0) begin failures++;
            $display("FAIL midfill_counters got %0d/%0d exp 0/0", bus.hit_count, bus.miss_count); end
        bus.cpu_read = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        access(1'b1, 1'b0, 16'h0002, 16'h0);
        checks++; if (o_lat !== 5 || o_rdata !== 16'hFFFF || bus.miss_count !== 16'd1) begin failures++;
            $display("FAIL reread_miss got lat=%0d rdata=%h miss=%0d exp 5/ffff/1", o_lat, o_rdata, bus.miss_count); end
    endtask

    task automatic test_read_write_both();
        access(1'b1, 1'b1, 16'h0000, 16'h1234);
        checks++; if (o_lat !== 1 || o_rdata !== 16'h1234) begin failures++;
            $display("FAIL rw_store got lat=%0d rdata=%h exp 1/1234", o_lat, o_rdata); end
        access(1'b1, 1'b0, 16'h0000, 16'h0);
        checks++; if (o_rdata !== 16'h1234) begin failures++; $display("FAIL rw_readback got=%h exp=1234", o_rdata); end
    endtask

    task automatic test_random();
        logic rd, wr;
        logic [15:0] addr, wd;
        for (int n = 0; n < 300; n++) begin
            rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 255)); wd = 16'($urandom);
            if (!rd && !wr) begin
                @(posedge clk); #1;
                checks++; if (bus.cpu_ready !== 1'b0) begin failures++; $display("FAIL rnd_idle_ready got=%b exp=0", bus.cpu_ready); end
            end else begin
                access(rd, wr, addr, wd);
                checks++; if (o_lat !== e_lat || o_rdata !== e_rdata) begin failures++;
                    $display("FAIL rnd_access n=%0d addr=%h got lat=%0d rdata=%h exp %0d/%h", n, addr, o_lat, o_rdata, e_lat, e_rdata); end
                checks++; if (o_nrd !== e_nrd || o_nwr !== e_nwr || o_both !== 0) begin failures++;
                    $display("FAIL rnd_strobes n=%0d got rd=%0d wr=%0d both=%0d exp %0d/%0d/0", n, o_nrd, o_nwr, o_both, e_nrd, e_nwr); end
                if (!e_hit) begin
                    checks++; if (o_rd_addr !== e_rd_addr) begin failures++;
                        $display("FAIL rnd_fill_addr n=%0d got=%h exp=%h", n, o_rd_addr, e_rd_addr); end
                end
                if (e_dirty) begin
                    checks++; if (o_wr_addr !== e_wb_addr || o_wr_data !== e_wb_data) begin failures++;
                        $display("FAIL rnd_wb n=%0d got %h:%h exp %h:%h", n, o_wr_addr, o_wr_data, e_wb_addr, e_wb_data); end
                end
            end
        end
        checks++; if (bus.hit_count !== 16'(exp_hit) || bus.miss_count !== 16'(exp_miss)) begin failures++;
            $display("FAIL rnd_counters got %0d/%0d exp %0d/%0d", bus.hit_count, bus.miss_count, exp_hit, exp_miss); end
    endtask

    initial begin
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = 16'h0; bus.cpu_wdata = 16'h0;
        mem[0] = 64'h9023_0001_FFFF_0000;
        for (int b = 1; b < 64; b++) mem[b] = {$urandom, $urandom};
        test_reset();
        test_cold_read();
        test_hit_read();
        test_dirty_evict();
        test_writeback_reload();
        test_reset_mid_fill();
        test_read_write_both();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
